mem_bus_arbiter: RTL and testbench

- Owns the shared RAM address/data bus and shares it between two masters: the CPU fetch/execute path (master 0) and a debug/boot loader port (master 1).
- The debug loader performs memory sweeps, image loads and dumps.
- Replaces ad-hoc forcing of address_bus/OE_M/WE_M with a req/gnt/done handshake, round-robin arbitration, a bounded bus lock for bursts, and out-of-range address rejection.
- Sits between the masters and the RAM instance inside cpu_m.

---
 rtl/mem_bus_pkg.sv | 20 ++
 rtl/rr_arb2.sv | 24 ++
 rtl/mem_bus_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_bus_pkg.sv
// Shared definitions for the RAM bus arbiter: default sizes, FSM encoding and master IDs.
package mem_bus_pkg;

  localparam int DEF_MEMORY_DEPTH = 32768;
  localparam int DEF_DATA_WIDTH   = 8;
  localparam int DEF_ADDR_WIDTH   = 16;
  localparam int DEF_MAX_LOCK     = 16;

  // Bus FSM: IDLE arbitrates, ACCESS drives the RAM for one cycle, DONE reports.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } bus_state_t;

  // Master identifiers (also the round-robin winner index).
  localparam logic M_CPU = 1'b0;
  localparam logic M_DBG = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick: a lone requester wins, a tie goes to the master
// that did not win last time.
module rr_arb2
  import mem_bus_pkg::*;
(
  input  logic [1:0] i_req,
  input  logic       i_last_winner,
  output logic       o_winner,
  output logic       o_valid
);

  // Combinational winner selection.
  always_comb begin
    o_valid  = |i_req;
    o_winner = M_CPU;
    case (i_req)
      2'b01:   o_winner = M_CPU;
      2'b10:   o_winner = M_DBG;
      2'b11:   o_winner = ~i_last_winner;
      default: o_winner = M_CPU;
    endcase
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares the RAM address/data bus between the CPU (master 0) and the debug
// loader (master 1) with round-robin arbitration, a bounded burst lock for
// master 1 and rejection of out-of-range addresses.
//
// Handshake: a master raises req with addr/we/wdata stable and holds them
// until its done pulse. gnt rises the cycle after req is sampled in IDLE and
// the inputs are latched at that edge, so later changes are ignored. done is a
// single-cycle pulse (err and rdata valid with it); gnt stays high through
// done. Dropping req early does not cancel an already granted transaction.
module mem_bus_arbiter
  import mem_bus_pkg::*;
#(
  parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int MEMORY_DEPTH = DEF_MEMORY_DEPTH,
  parameter int MAX_LOCK     = DEF_MAX_LOCK
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  m0_req,
  input  logic                  m0_we,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [DATA_WIDTH-1:0] m0_wdata,
  input  logic                  m1_req,
  input  logic                  m1_we,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [DATA_WIDTH-1:0] m1_wdata,
  input  logic                  m1_lock,
  output logic                  m0_gnt,
  output logic                  m1_gnt,
  output logic                  m0_done,
  output logic                  m1_done,
  output logic                  m0_err,
  output logic                  m1_err,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic [ADDR_WIDTH-1:0] address_bus,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  OE_M,
  output logic                  WE_M,
  output logic [1:0]            dbg_state
);

  localparam int LCW = (MAX_LOCK > 1) ? $clog2(MAX_LOCK) : 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_LIM = (ADDR_WIDTH + 1)'(MEMORY_DEPTH);
  localparam logic [LCW-1:0]      LOCK_LAST = LCW'(MAX_LOCK - 1);

  bus_state_t            r_state;
  logic                  r_owner;
  logic                  r_last_winner;
  logic [LCW-1:0]        r_lock_cnt;
  logic                  r_we_lat;
  logic                  r_oor;
  logic                  r_m0_gnt;
  logic                  r_m1_gnt;
  logic                  r_m0_done;
  logic                  r_m1_done;
  logic                  r_m0_err;
  logic                  r_m1_err;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic [ADDR_WIDTH-1:0] r_address_bus;
  logic [DATA_WIDTH-1:0] r_mem_wdata;
  logic                  r_oe;
  logic                  r_we_m;

  logic                  w_arb_winner;
  logic                  w_arb_valid;
  logic                  w_lock_follow;
  logic                  w_load;
  logic                  w_ld_sel;
  logic                  w_ld_we;
  logic [ADDR_WIDTH-1:0] w_ld_addr;
  logic [DATA_WIDTH-1:0] w_ld_wdata;
  logic                  w_ld_in_range;

  rr_arb2 u_rr_arb2 (
    .i_req         ({m1_req, m0_req}),
    .i_last_winner (r_last_winner),
    .o_winner      (w_arb_winner),
    .o_valid       (w_arb_valid)
  );

  // Pick which master's request is loaded into ACCESS: the arbiter winner
  // from IDLE, or master 1 again for a locked follow-on from DONE.
  always_comb begin
    w_lock_follow = (r_state == ST_DONE) && (r_owner == M_DBG) &&
                    m1_lock && m1_req && (r_lock_cnt < LOCK_LAST);
    w_load        = ((r_state == ST_IDLE) && w_arb_valid) || w_lock_follow;
    w_ld_sel      = (r_state == ST_IDLE) ? w_arb_winner : M_DBG;
    w_ld_we       = w_ld_sel ? m1_we    : m0_we;
    w_ld_addr     = w_ld_sel ? m1_addr  : m0_addr;
    w_ld_wdata    = w_ld_sel ? m1_wdata : m0_wdata;
    w_ld_in_range = ({1'b0, w_ld_addr} < DEPTH_LIM);
  end

  // Bus FSM with registered handshake and RAM-side outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= ST_IDLE;
      r_owner       <= M_CPU;
      r_last_winner <= M_DBG;
      r_lock_cnt    <= '0;
      r_we_lat      <= 1'b0;
      r_oor         <= 1'b0;
      r_m0_gnt      <= 1'b0;
      r_m1_gnt      <= 1'b0;
      r_m0_done     <= 1'b0;
      r_m1_done     <= 1'b0;
      r_m0_err      <= 1'b0;
      r_m1_err      <= 1'b0;
      r_rdata       <= '0;
      r_address_bus <= '0;
      r_mem_wdata   <= '0;
      r_oe          <= 1'b0;
      r_we_m        <= 1'b0;
    end else begin
      if (w_load) begin
        r_owner       <= w_ld_sel;
        r_we_lat      <= w_ld_we;
        r_oor         <= ~w_ld_in_range;
        r_address_bus <= w_ld_addr;
        r_mem_wdata   <= w_ld_wdata;
        r_oe          <= w_ld_in_range & ~w_ld_we;
        r_we_m        <= w_ld_in_range & w_ld_we;
        r_m0_gnt      <= (w_ld_sel == M_CPU);
        r_m1_gnt      <= (w_ld_sel == M_DBG);
        r_state       <= ST_ACCESS;
      end
      case (r_state)
        ST_IDLE: begin
          r_lock_cnt <= '0;
        end
        ST_ACCESS: begin
          r_oe          <= 1'b0;
          r_we_m        <= 1'b0;
          r_address_bus <= '0;
          r_mem_wdata   <= '0;
          if (r_oor) begin
            r_rdata <= '0;
          end else if (!r_we_lat) begin
            r_rdata <= mem_rdata;
          end
          r_m0_done <= (r_owner == M_CPU);
          r_m1_done <= (r_owner == M_DBG);
          r_m0_err  <= (r_owner == M_CPU) && r_oor;
          r_m1_err  <= (r_owner == M_DBG) && r_oor;
          r_state   <= ST_DONE;
        end
        ST_DONE: begin
          r_m0_done     <= 1'b0;
          r_m1_done     <= 1'b0;
          r_m0_err      <= 1'b0;
          r_m1_err      <= 1'b0;
          r_last_winner <= r_owner;
          if (w_lock_follow) begin
            r_lock_cnt <= r_lock_cnt + 1'b1;
          end else begin
            r_m0_gnt   <= 1'b0;
            r_m1_gnt   <= 1'b0;
            r_lock_cnt <= '0;
            r_state    <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign m0_gnt      = r_m0_gnt;
  assign m1_gnt      = r_m1_gnt;
  assign m0_done     = r_m0_done;
  assign m1_done     = r_m1_done;
  assign m0_err      = r_m0_err;
  assign m1_err      = r_m1_err;
  assign rdata       = r_rdata;
  assign address_bus = r_address_bus;
  assign mem_wdata   = r_mem_wdata;
  assign OE_M        = r_oe;
  assign WE_M        = r_we_m;
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: directed vector table, contention, lock-break and
// reset-abort sequences, then randomized traffic from both masters checked
// against a transaction-level memory model.
`timescale 1ns/1ps
module tb_mem_bus_arbiter;
  import mem_bus_pkg::*;

  localparam int AW    = 16;
  localparam int DW    = 8;
  localparam int DEPTH = 32768;
  localparam int MAXL  = 16;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          lock;
  } txn_t;

  typedef struct packed {
    logic          m;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] exp_rd;
    logic          exp_err;
    logic          exp_oe;
    logic          exp_we;
  } vec_t;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [1:0]    req   = '0;
  logic [1:0]    we_i  = '0;
  logic          lock  = 1'b0;
  logic [AW-1:0] addr_i  [2];
  logic [DW-1:0] wdata_i [2];

  logic m0_gnt, m1_gnt, m0_done, m1_done, m0_err, m1_err, oe_m, we_m;
  logic [DW-1:0] rdata, mem_wdata, mem_rdata;
  logic [AW-1:0] address_bus;
  logic [1:0]    dbg_state;

  mem_bus_arbiter dut (
    .clk         (clk),
    .reset       (reset),
    .m0_req      (req[0]),
    .m0_we       (we_i[0]),
    .m0_addr     (addr_i[0]),
    .m0_wdata    (wdata_i[0]),
    .m1_req      (req[1]),
    .m1_we       (we_i[1]),
    .m1_addr     (addr_i[1]),
    .m1_wdata    (wdata_i[1]),
    .m1_lock     (lock),
    .m0_gnt      (m0_gnt),
    .m1_gnt      (m1_gnt),
    .m0_done     (m0_done),
    .m1_done     (m1_done),
    .m0_err      (m0_err),
    .m1_err      (m1_err),
    .rdata       (rdata),
    .address_bus (address_bus),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .OE_M        (oe_m),
    .WE_M        (we_m),
    .dbg_state   (dbg_state)
  );

  // RAM attached to the bus: combinational read, write on the rising edge.
  logic [DW-1:0] ram [0:DEPTH-1];
  assign mem_rdata = ram[address_bus[14:0]];
  always @(posedge clk) if (we_m) ram[address_bus[14:0]] <= mem_wdata;

  // ---------------- scoreboard state ----------------
  int passes = 0;
  int checks = 0;
  int cyc    = 0;
  logic [DW-1:0] ref_mem [0:DEPTH-1];
  logic [DW-1:0] rd_model = '0;
  logic [DW-1:0] exp_q[$];
  int            done_log[$];
  int            done_cyc[$];
  int            bus_cnt   = 0;
  logic [AW-1:0] bus_addr  = '0;
  logic          bus_we    = 1'b0;
  logic [DW-1:0] bus_wdata = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got 0x%0h required 0x%0h (t=%0t)", name, got, exp, $time);
  endtask

  // Per-cycle bus invariants and capture of RAM-side activity.
  always @(negedge clk) begin
    if (reset) begin
      check("bus_invariants",
            {25'd0, oe_m && we_m, m0_gnt && m1_gnt, (oe_m || we_m) && !(m0_gnt || m1_gnt),
             m0_done && !m0_gnt, m1_done && !m1_gnt, m0_err && !m0_done, m1_err && !m1_done},
            32'd0);
      if (oe_m || we_m) begin
        bus_cnt++;
        bus_addr  = address_bus;
        bus_we    = we_m;
        bus_wdata = mem_wdata;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b0;
    req   = '0;
    lock  = 1'b0;
    repeat (2) @(negedge clk);
    reset    = 1'b1;
    bus_cnt  = 0;
    rd_model = '0;
    done_log.delete();
    done_cyc.delete();
  endtask

  // Issue one transaction for master m, wait for its done and score it.
  // gap = 0 keeps req high for an immediate next call; gap > 0 drops req.
  task automatic master_txn(input int m, input txn_t t, input int gap);
    int            waited;
    logic [1:0]    dn;
    logic          in_rng;
    logic [DW-1:0] exp_rd;
    waited     = 0;
    req[m]     = 1'b1;
    we_i[m]    = t.we;
    addr_i[m]  = t.addr;
    wdata_i[m] = t.wdata;
    if (m == 1) lock = t.lock;
    do begin
      @(negedge clk);
      waited++;
      dn = {m1_done, m0_done};
    end while (!dn[m] && waited < 200);
    if (!dn[m]) begin
      checks++;
      $display("FAIL m%0d_done_timeout: got no done after %0d cycles, required done", m, waited);
    end else begin
      done_log.push_back(m);
      done_cyc.push_back(cyc);
      in_rng = (int'(t.addr) < DEPTH);
      if (!in_rng)   exp_rd = '0;
      else if (t.we) exp_rd = rd_model;
      else           exp_rd = ref_mem[t.addr[14:0]];
      exp_q.push_back(exp_rd);
      check($sformatf("m%0d_rdata@%0h", m, t.addr), rdata, exp_q.pop_front());
      check($sformatf("m%0d_err@%0h", m, t.addr), (m == 1) ? m1_err : m0_err, in_rng ? 0 : 1);
      check($sformatf("m%0d_gnt_at_done", m), {m1_gnt, m0_gnt}, (m == 1) ? 2 : 1);
      check($sformatf("m%0d_bus_cycles@%0h", m, t.addr), bus_cnt, in_rng ? 1 : 0);
      if (in_rng) check($sformatf("m%0d_bus_cmd", m), {bus_we, bus_addr}, {t.we, t.addr});
      if (in_rng && t.we) check($sformatf("m%0d_bus_wdata", m), bus_wdata, t.wdata);
      rd_model = exp_rd;
      if (in_rng && t.we) ref_mem[t.addr[14:0]] = t.wdata;
      bus_cnt = 0;
    end
    if (gap > 0) begin
      req[m] = 1'b0;
      if (m == 1) lock = 1'b0;
      repeat (gap) @(negedge clk);
    end
  endtask

  function automatic txn_t rand_txn(input int m);
    txn_t t;
    int   sel;
    sel     = $urandom_range(0, 9);
    t.we    = 1'($urandom_range(0, 1));
    if (sel < 6)      t.addr = 16'($urandom_range(0, 15));
    else if (sel < 8) t.addr = 16'h7FF0 + 16'($urandom_range(0, 15));
    else              t.addr = 16'h8000 + 16'($urandom_range(0, 32767));
    t.wdata = 8'($urandom_range(0, 255));
    t.lock  = (m == 1) && ($urandom_range(0, 2) == 0);
    return t;
  endfunction

  // ---------------- test sequence ----------------
  vec_t vecs [10];

  initial begin
    logic [DW-1:0] saved;
    vec_t v;

    vecs[0] = '{1'b0, 1'b0, 16'h0002, 8'h00, 8'hA5, 1'b0, 1'b1, 1'b0};
    vecs[1] = '{1'b1, 1'b1, 16'h0010, 8'h25, 8'hA5, 1'b0, 1'b0, 1'b1};
    vecs[2] = '{1'b1, 1'b0, 16'h0010, 8'h00, 8'h25, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{1'b1, 1'b0, 16'h8000, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{1'b0, 1'b0, 16'h0003, 8'h00, 8'h3F, 1'b0, 1'b1, 1'b0};
    vecs[5] = '{1'b0, 1'b0, 16'h7FFF, 8'h00, 8'hC3, 1'b0, 1'b1, 1'b0};
    vecs[6] = '{1'b0, 1'b1, 16'hFFFF, 8'h77, 8'h00, 1'b1, 1'b0, 1'b0};
    vecs[7] = '{1'b1, 1'b1, 16'h7FFF, 8'h5E, 8'h00, 1'b0, 1'b0, 1'b1};
    vecs[8] = '{1'b0, 1'b0, 16'h7FFF, 8'h00, 8'h5E, 1'b0, 1'b1, 1'b0};
    vecs[9] = '{1'b1, 1'b0, 16'h0002, 8'h00, 8'hA5, 1'b0, 1'b1, 1'b0};

    for (int i = 0; i < DEPTH; i++) begin
      ram[i]     = 8'(i) ^ 8'h3C;
      ref_mem[i] = 8'(i) ^ 8'h3C;
    end
    ram[2]     = 8'hA5;
    ref_mem[2] = 8'hA5;
    addr_i[0]  = '0; addr_i[1]  = '0;
    wdata_i[0] = '0; wdata_i[1] = '0;

    // Reset state.
    #1 reset = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_handshake", {m1_gnt, m0_gnt, m1_done, m0_done, m1_err, m0_err, oe_m, we_m}, 0);
    check("rst_address_bus", address_bus, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_rdata", rdata, 0);
    check("rst_state", dbg_state, 2'(ST_IDLE));
    reset = 1'b1;

    // Directed single-master vectors with exact cycle timing.
    for (int i = 0; i < 10; i++) begin
      v = vecs[i];
      @(negedge clk);
      req[v.m] = 1'b1; we_i[v.m] = v.we; addr_i[v.m] = v.addr; wdata_i[v.m] = v.wdata;
      @(negedge clk);
      check($sformatf("v%0d_gnt", i), {m1_gnt, m0_gnt}, v.m ? 2 : 1);
      check($sformatf("v%0d_oe_we", i), {oe_m, we_m}, {v.exp_oe, v.exp_we});
      check($sformatf("v%0d_address_bus", i), address_bus, v.addr);
      if (v.exp_we) check($sformatf("v%0d_mem_wdata", i), mem_wdata, v.wdata);
      check($sformatf("v%0d_no_early_done", i), {m1_done, m0_done}, 0);
      @(negedge clk);
      check($sformatf("v%0d_done", i), {m1_done, m0_done}, v.m ? 2 : 1);
      check($sformatf("v%0d_err", i), {m1_err, m0_err}, v.exp_err ? (v.m ? 2 : 1) : 0);
      check($sformatf("v%0d_rdata", i), rdata, v.exp_rd);
      check($sformatf("v%0d_oe_we_off", i), {oe_m, we_m}, 0);
      req[v.m] = 1'b0;
      @(negedge clk);
      check($sformatf("v%0d_release", i), {m1_gnt, m0_gnt, m1_done, m0_done}, 0);
      if (v.exp_we) ref_mem[v.addr[14:0]] = v.wdata;
      rd_model = v.exp_rd;
      bus_cnt  = 0;
    end

    // Contention from reset: m0, m1, m0, m1, three cycles apart.
    apply_reset();
    fork
      begin
        master_txn(0, '{1'b0, 16'h0004, 8'h00, 1'b0}, 0);
        master_txn(0, '{1'b1, 16'h0005, 8'h11, 1'b0}, 1);
      end
      begin
        master_txn(1, '{1'b0, 16'h0006, 8'h00, 1'b0}, 0);
        master_txn(1, '{1'b0, 16'h0005, 8'h00, 1'b0}, 1);
      end
    join
    check("cont_count", done_log.size(), 4);
    if (done_log.size() == 4) begin
      for (int k = 0; k < 4; k++) check($sformatf("cont_order%0d", k), done_log[k], k % 2);
      for (int k = 1; k < 4; k++)
        check($sformatf("cont_spacing%0d", k), done_cyc[k] - done_cyc[k-1], 3);
    end

    // Lock: 20 locked m1 requests, m0 waiting; m0 gets in after 16.
    done_log.delete();
    done_cyc.delete();
    fork
      begin
        for (int i = 0; i < 20; i++)
          master_txn(1, '{(i % 3 == 0), 16'(16'h0020 + i), 8'(i * 7), 1'b1}, (i == 19) ? 1 : 0);
      end
      begin
        @(negedge clk);
        master_txn(0, '{1'b0, 16'h0021, 8'h00, 1'b0}, 1);
      end
    join
    check("lock_count", done_log.size(), 21);
    if (done_log.size() == 21) begin
      for (int k = 0; k < MAXL; k++) check($sformatf("lock_owner%0d", k), done_log[k], 1);
      for (int k = 1; k < MAXL; k++)
        check($sformatf("lock_spacing%0d", k), done_cyc[k] - done_cyc[k-1], 2);
      check("lock_break_m0", done_log[MAXL], 0);
      check("lock_break_gap", done_cyc[MAXL] - done_cyc[MAXL-1], 3);
      check("lock_resume_m1", done_log[MAXL+1], 1);
    end

    // Reset during ACCESS of an m0 write aborts it at once.
    @(negedge clk);
    saved = ram[16'h0040];
    req[0] = 1'b1; we_i[0] = 1'b1; addr_i[0] = 16'h0040; wdata_i[0] = 8'h99;
    @(negedge clk);
    check("abort_we_before", we_m, 1);
    reset = 1'b0;
    #1;
    check("abort_immediate", {we_m, oe_m, m0_gnt, m1_gnt}, 0);
    req[0] = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check("abort_no_done", {m1_done, m0_done}, 0);
    end
    check("abort_ram_untouched", ram[16'h0040], saved);
    reset    = 1'b1;
    bus_cnt  = 0;
    rd_model = '0;
    done_log.delete();
    done_cyc.delete();
    fork
      master_txn(0, '{1'b0, 16'h0041, 8'h00, 1'b0}, 1);
      master_txn(1, '{1'b0, 16'h0042, 8'h00, 1'b0}, 1);
    join
    check("post_reset_count", done_log.size(), 2);
    if (done_log.size() == 2) begin
      check("post_reset_first_m0", done_log[0], 0);
      check("post_reset_second_m1", done_log[1], 1);
    end

    // Randomized traffic from both masters.
    fork
      begin
        for (int i = 0; i < 40; i++)
          master_txn(0, rand_txn(0), (i == 39) ? 1 : int'($urandom_range(0, 2)));
      end
      begin
        for (int i = 0; i < 40; i++)
          master_txn(1, rand_txn(1), (i == 39) ? 1 : int'($urandom_range(0, 2)));
      end
    join

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  // Global time limit.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit, required completion");
    $fatal(1);
  end

endmodule
